fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write arbiter that shares the write port of one 8-bit FIFO between several producers in the write clock domain. It latches one requester's word, waits for the FIFO to be not full, drives a single-cycle `insert` with the data, and returns a one-cycle grant to the winner. It sits directly in front of the FIFO write side (`insert`/`data_in`/`full`) and is the only block allowed to drive those signals.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, word width; must match the FIFO data width
- clk_in  input  1  write-domain clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort: drop the latched word, return to IDLE
- req  input  NUM_REQ  per-requester write request, level
- req_data  input  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
- fifo_full  input  1  FIFO full flag
- gnt  output  NUM_REQ  one-hot, one-cycle pulse: winner's word accepted
- insert  output  1  FIFO write strobe, one cycle per word
- data_out  output  DATA_W  word to FIFO `data_in`, valid when `insert`=1
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE.
- IDLE: if `flush`=1, stay. Else if `req`≠0, pick the winner as the first set bit searching upward from `last+1` with wrap (modulo NUM_REQ). Latch winner index `sel` and `req_data[sel]`, then go to ISSUE. If `req`=0, stay.
- ISSUE with `flush`=1: go to IDLE. No `insert`, no `gnt`, `last` unchanged. Flush has priority over everything.
- ISSUE with `fifo_full`=1: hold. `insert`=0.
- ISSUE with `fifo_full`=0: `insert`=1, `data_out`=latched word, `gnt[sel]`=1, `last`←`sel`, go to IDLE.
- `insert`, `gnt` and `data_out` are registered outputs. `data_out` holds its last value when `insert`=0.
- Requester rule: hold `req` and `req_data` stable until `gnt`. The latched word is issued even if `req` drops after latching.
- `last` width is clog2(NUM_REQ). Reset value is NUM_REQ-1, so requester 0 has first priority after reset.
- Requester indices ≥ NUM_REQ do not exist. `gnt` never has more than one bit set.

## Timing
- Reset values: `gnt`=0, `insert`=0, `data_out`=0, `busy`=0, state=IDLE, `last`=NUM_REQ-1.
- Reset is asynchronous and may assert in any state. The latched word is discarded and no `insert` is emitted after reset asserts.
- Latency: `req` sampled in IDLE at edge N. `insert` and `gnt` are high during the cycle after edge N+1, provided `fifo_full`=0 at edge N+1.
- Peak throughput: one word per 2 cycles.
- `fifo_full` is sampled at each ISSUE edge. A word is never issued on an edge where `fifo_full`=1.
- The same requester cannot win twice in a row while another requester is asserting `req`.

## Configuration
- FIFO_ARB_STALL_CNT_EN defined: adds output `stall_cnt` [15:0].
  - Counts ISSUE cycles held by `fifo_full`=1.
  - Saturates at 16'hFFFF.
  - Cleared by `reset` only.
- Not defined: no `stall_cnt` port and no counter logic. All other behaviour is identical.

## Structure
- Package `fifo_arb_pkg` holds:
  - state encoding constants ST_IDLE=1'b0, ST_ISSUE=1'b1
  - default NUM_REQ and DATA_W
  - STALL_CNT_W=16
- Sub-module `rr_pick`: combinational round-robin picker. Inputs `req` and `last`; outputs one-hot `win` and index `win_idx`. Instantiated once in the IDLE arbitration path.

## Test plan
- Reset, then `req`=4'b0001, data0=8'hA5, `fifo_full`=0 → `insert`=1 and `data_out`=8'hA5 two cycles later; `gnt`=4'b0001 for exactly one cycle.
- `req`=4'b1111 held, `fifo_full`=0 → grant order 0,1,2,3,0,…; one `insert` every 2 cycles; no grant repeats consecutively.
- Latch requester 2, hold `fifo_full`=1 for 5 cycles → no `insert` during those 5 cycles; `insert` appears in the cycle after `fifo_full` drops; `stall_cnt`=5 when FIFO_ARB_STALL_CNT_EN is defined.
- `flush`=1 while in ISSUE with 8'h3C latched → back to IDLE; no `insert`, no `gnt`; next grant still starts from the same `last`.
- Assert `reset` mid-ISSUE → all outputs 0 immediately; after release, `req`=4'b1010 → requester 1 wins first.
- `req`=4'b0100 dropped right after latching → word still issued with `gnt`=4'b0100.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and default sizes for the FIFO write arbiter.
package fifo_arb_pkg;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;
    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int STALL_CNT_W = 16;
endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit searching upward from last+1 with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  win,
    output logic [LW-1:0] win_idx
);
    always_comb begin
        win     = '0;
        win_idx = '0;
        // Walk from the farthest offset down so the nearest requester overwrites last.
        for (int k = N; k >= 1; k--) begin
            if (req[LW'((int'(last) + k) % N)]) begin
                win_idx = LW'((int'(last) + k) % N);
                win     = '0;
                win[LW'((int'(last) + k) % N)] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one FIFO write port between NUM_REQ producers.
// Optional FIFO_ARB_STALL_CNT_EN adds a saturating count of ISSUE cycles held by fifo_full.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      fifo_full,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      insert,
    output logic [DATA_W-1:0]         data_out,
`ifdef FIFO_ARB_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0]    stall_cnt,
`endif
    output logic                      busy
);
    localparam int LW = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    logic [LW-1:0]       last_q, last_d, sel_q, sel_d, win_idx;
    logic [NUM_REQ-1:0]  sel_oh_q, sel_oh_d, win, gnt_q, gnt_d;
    logic [DATA_W-1:0]   word_q, word_d, dout_q, dout_d;
    logic                insert_q, insert_d, take, issue;

    rr_pick #(.N(NUM_REQ), .LW(LW)) u_pick (
        .req     (req),
        .last    (last_q),
        .win     (win),
        .win_idx (win_idx)
    );

    assign take  = state_q == ST_IDLE && !flush && |req;
    assign issue = state_q == ST_ISSUE && !flush && !fifo_full;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= LW'(NUM_REQ - 1);
            sel_q    <= '0;
            sel_oh_q <= '0;
            word_q   <= '0;
            gnt_q    <= '0;
            insert_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            sel_oh_q <= sel_oh_d;
            word_q   <= word_d;
            gnt_q    <= gnt_d;
            insert_q <= insert_d;
            dout_q   <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_ISSUE && (flush || !fifo_full)) state_d = ST_IDLE;
        else if (take) state_d = ST_ISSUE;
    end

    always_comb begin
        sel_d    = take ? win_idx : sel_q;
        sel_oh_d = take ? win : sel_oh_q;
        word_d   = take ? req_data[win_idx*DATA_W +: DATA_W] : word_q;
        last_d   = issue ? sel_q : last_q;
        gnt_d    = issue ? sel_oh_q : '0;
        insert_d = issue;
        dout_d   = issue ? word_q : dout_q;
    end

    assign gnt      = gnt_q;
    assign insert   = insert_q;
    assign data_out = dout_q;
    assign busy     = state_q != ST_IDLE;

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) stall_q <= '0;
        else if (state_q == ST_ISSUE && !flush && fifo_full && stall_q != '1) stall_q <= stall_q + STALL_CNT_W'(1);
    end
    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scoreboard bench for fifo_write_arbiter, expected grants queued at stimulus time.
module tb_fifo_write_arbiter;
    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        fifo_full = 1'b0;
    logic [3:0]  gnt;
    logic        insert;
    logic [7:0]  data_out;
    logic        busy;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_ins = 0;
    int   ins_before;

    fifo_write_arbiter dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .flush     (flush),
        .req       (req),
        .req_data  (req_data),
        .fifo_full (fifo_full),
        .gnt       (gnt),
        .insert    (insert),
        .data_out  (data_out),
`ifdef FIFO_ARB_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic expect_win(input int idx, input logic [7:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        sb.push_back(e);
    endtask

    always @(negedge clk_in) begin
        if (!reset) begin
            chk("gnt_vs_insert", {31'b0, |gnt}, {31'b0, insert});
            if (insert) begin
                n_ins++;
                if (sb.size() == 0) chk("spurious_insert", {31'b0, insert}, 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("gnt", {28'b0, gnt}, 32'(4'b0001 << e.idx));
                    chk("data_out", {24'b0, data_out}, {24'b0, e.data});
                end
            end
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_gnt", {28'b0, gnt}, 32'd0);
        chk("rst_insert", {31'b0, insert}, 32'd0);
        chk("rst_data", {24'b0, data_out}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;

        // single requester, two-cycle latency
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        expect_win(0, 8'hA5);
        tick();
        chk("t1_busy", {31'b0, busy}, 32'd1);
        chk("t1_no_early_insert", {31'b0, insert}, 32'd0);
        tick();
        req = '0;
        chk("t1_insert", {31'b0, insert}, 32'd1);
        tick();
        chk("t1_one_cycle", {31'b0, insert}, 32'd0);

        // all requesting: rotation starting after last=0
        req_data = 32'h13121110;
        req = 4'b1111;
        ins_before = n_ins;
        for (int r = 0; r < 2; r++) begin
            expect_win(1, 8'h11);
            expect_win(2, 8'h12);
            expect_win(3, 8'h13);
            expect_win(0, 8'h10);
        end
        repeat (16) tick();
        req = '0;
        tick();
        chk("t2_rate", 32'(n_ins - ins_before), 32'd8);

        // stall on full, requester 2
        req_data[23:16] = 8'h77;
        fifo_full = 1'b1;
        req = 4'b0100;
        expect_win(2, 8'h77);
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_stall_insert", {31'b0, insert}, 32'd0);
        end
        fifo_full = 1'b0;
        tick();
        req = '0;
        chk("t3_insert_after_full", {31'b0, insert}, 32'd1);
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("t3_stall_cnt", {16'b0, stall_cnt}, 32'd5);
`endif
        tick();

        // flush in ISSUE discards 3C, last stays 2
        req_data[15:8] = 8'h3C;
        req = 4'b0010;
        tick();
        req = '0;
        flush = 1'b1;
        tick();
        chk("t4_flush_insert", {31'b0, insert}, 32'd0);
        chk("t4_flush_busy", {31'b0, busy}, 32'd0);
        req = 4'b1000;
        tick();
        chk("t4_flush_idle_hold", {31'b0, busy}, 32'd0);
        flush = 1'b0;
        req_data[15:8] = 8'h5A;
        req_data[23:16] = 8'h66;
        req = 4'b0110;
        expect_win(1, 8'h5A);
        tick();
        tick();
        req = '0;
        tick();

        // async reset while stalled in ISSUE
        fifo_full = 1'b1;
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_data", {24'b0, data_out}, 32'd0);
        chk("t5_rst_busy", {31'b0, busy}, 32'd0);
        chk("t5_rst_gnt", {28'b0, gnt}, 32'd0);
        tick();
        reset = 1'b0;
        fifo_full = 1'b0;
        req_data = 32'h44332211;
        req = 4'b1010;
        expect_win(1, 8'h22);
        tick();
        tick();
        req = '0;
        tick();

        // request dropped right after latching
        req_data[23:16] = 8'hC3;
        req = 4'b0100;
        expect_win(2, 8'hC3);
        tick();
        req = '0;
        tick();
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
